// File: rtl/interval_timer_pkg.sv
// Shared definitions for the interval timer: state encoding and default sizing.
package interval_timer_pkg;

    localparam logic TIMER_IDLE = 1'b0;
    localparam logic TIMER_RUN  = 1'b1;

    localparam int unsigned DEFAULT_PRESCALE     = 4;
    localparam int unsigned DEFAULT_PERIOD_WIDTH = 16;

    typedef enum logic {
        StIdle = TIMER_IDLE,
        StRun  = TIMER_RUN
    } timer_state_e;

endpackage

// File: rtl/interval_timer_tick_prescaler.sv
// Divides clk into a one-cycle tick every PRESCALE enabled cycles.
module interval_timer_tick_prescaler
    import interval_timer_pkg::*;
#(
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE,
    parameter int unsigned PS_WIDTH = $clog2(PRESCALE + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    logic [PS_WIDTH-1:0] count_q;
    logic                at_wrap;

    assign at_wrap = (count_q == PS_WIDTH'(PRESCALE - 1));
    assign tick    = at_wrap && enable;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= at_wrap ? '0 : count_q + PS_WIDTH'(1);
        end
    end

endmodule

// File: rtl/interval_timer.sv
// Programmable one-shot / periodic interval timer on a prescaled tick with a
// valid/ready start handshake and a registered single-cycle expire pulse.
module interval_timer
    import interval_timer_pkg::*;
#(
    parameter int unsigned PRESCALE     = DEFAULT_PRESCALE,
    parameter int unsigned PERIOD_WIDTH = DEFAULT_PERIOD_WIDTH,
    parameter int unsigned PS_WIDTH     = $clog2(PRESCALE + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [PERIOD_WIDTH-1:0] start_period,
    input  logic                    start_periodic,
    input  logic                    stop,
    output logic                    busy,
    output logic                    expire,
    output logic [PERIOD_WIDTH-1:0] remaining
);

    timer_state_e            state_q;
    logic [PERIOD_WIDTH-1:0] remaining_q;
    logic [PERIOD_WIDTH-1:0] period_q;
    logic                    periodic_q;
    logic                    expire_q;

    logic                    accept;
    logic                    abort;
    logic                    tick;
    logic [PERIOD_WIDTH-1:0] load_period;

    assign accept      = (state_q == StIdle) && start_valid;
    assign abort       = (state_q == StRun) && stop;
    // A zero period would never expire; run it as a single tick instead.
    assign load_period = (start_period == '0) ? PERIOD_WIDTH'(1) : start_period;

    interval_timer_tick_prescaler #(
        .PRESCALE (PRESCALE),
        .PS_WIDTH (PS_WIDTH)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept || abort),
        .enable (state_q == StRun),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            period_q    <= '0;
            periodic_q  <= 1'b0;
            expire_q    <= 1'b0;
        end else begin
            expire_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_valid) begin
                        state_q     <= StRun;
                        remaining_q <= load_period;
                        period_q    <= load_period;
                        periodic_q  <= start_periodic;
                    end
                end
                StRun: begin
                    // Stop takes priority, even over the terminal tick.
                    if (stop) begin
                        state_q     <= StIdle;
                        remaining_q <= '0;
                    end else if (tick) begin
                        if (remaining_q > PERIOD_WIDTH'(1)) begin
                            remaining_q <= remaining_q - PERIOD_WIDTH'(1);
                        end else begin
                            expire_q <= 1'b1;
                            if (periodic_q) begin
                                remaining_q <= period_q;
                            end else begin
                                state_q     <= StIdle;
                                remaining_q <= '0;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign start_ready = (state_q == StIdle);
    assign busy        = (state_q == StRun);
    assign expire      = expire_q;
    assign remaining   = remaining_q;

endmodule

// File: tb/tb_interval_timer.sv
// Directed scoreboard bench for interval_timer at PRESCALE 4, 2 and 1.
module tb_interval_timer;

    localparam int unsigned W = 16;

    typedef struct {
        string          tag;
        logic [W-1:0]   rem;
        logic           busy;
        logic           ready;
        logic           expire;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start_valid = 1'b0;
    logic [W-1:0] start_period = '0;
    logic         start_periodic = 1'b0;
    logic         stop = 1'b0;

    logic [2:0]   ready_v;
    logic [2:0]   busy_v;
    logic [2:0]   expire_v;
    logic [W-1:0] rem_v [3];

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    // Index 0: PRESCALE=4, 1: PRESCALE=2, 2: PRESCALE=1; all share stimulus.
    interval_timer #(.PRESCALE(4), .PERIOD_WIDTH(W)) u_p4 (
        .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(ready_v[0]),
        .start_period(start_period), .start_periodic(start_periodic), .stop(stop),
        .busy(busy_v[0]), .expire(expire_v[0]), .remaining(rem_v[0])
    );
    interval_timer #(.PRESCALE(2), .PERIOD_WIDTH(W)) u_p2 (
        .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(ready_v[1]),
        .start_period(start_period), .start_periodic(start_periodic), .stop(stop),
        .busy(busy_v[1]), .expire(expire_v[1]), .remaining(rem_v[1])
    );
    interval_timer #(.PRESCALE(1), .PERIOD_WIDTH(W)) u_p1 (
        .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(ready_v[2]),
        .start_period(start_period), .start_periodic(start_periodic), .stop(stop),
        .busy(busy_v[2]), .expire(expire_v[2]), .remaining(rem_v[2])
    );

    task automatic push(input string tag, input int rem, input logic b, input logic e);
        exp_t x;
        x.tag    = tag;
        x.rem    = W'(rem);
        x.busy   = b;
        x.ready  = !b;
        x.expire = e;
        exp_q.push_back(x);
    endtask

    task automatic check_pop(input int which);
        exp_t x;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: observed no entry, required one");
            return;
        end
        x = exp_q.pop_front();
        assert (busy_v[which] === x.busy) else begin
            miscompares++;
            $error("FAIL %s busy: observed %0b expected %0b", x.tag, busy_v[which], x.busy);
        end
        vectors++;
        assert (ready_v[which] === x.ready) else begin
            miscompares++;
            $error("FAIL %s ready: observed %0b expected %0b", x.tag, ready_v[which], x.ready);
        end
        vectors++;
        assert (expire_v[which] === x.expire) else begin
            miscompares++;
            $error("FAIL %s expire: observed %0b expected %0b", x.tag, expire_v[which],
                   x.expire);
        end
        vectors++;
        assert (rem_v[which] === x.rem) else begin
            miscompares++;
            $error("FAIL %s remaining: observed %0d expected %0d", x.tag, rem_v[which], x.rem);
        end
    endtask

    task automatic step(input int which);
        @(posedge clk);
        #1;
        check_pop(which);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        #1;
        for (int i = 0; i < 3; i++) begin
            push("reset_state", 0, 1'b0, 1'b0);
            check_pop(i);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;

        // One-shot, PRESCALE=4, period=3: expire on edge 12.
        start_valid = 1'b1; start_period = 3; start_periodic = 1'b0;
        for (int k = 0; k <= 13; k++) begin
            push("oneshot", (k < 4) ? 3 : (k < 8) ? 2 : (k < 12) ? 1 : 0, k < 12, k == 12);
            step(0);
            start_valid = 1'b0;
        end
        pulse_reset();

        // Asynchronous reset mid-run must clear without a clock edge.
        start_valid = 1'b1; start_period = 3; start_periodic = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            push("pre_reset", (k < 4) ? 3 : 2, 1'b1, 1'b0);
            step(0);
            start_valid = 1'b0;
        end
        reset = 1'b0;
        #2;
        push("async_reset", 0, 1'b0, 1'b0);
        check_pop(0);
        reset = 1'b1;
        for (int k = 6; k <= 13; k++) begin
            push("post_reset", 0, 1'b0, 1'b0);
            step(0);
        end

        // Periodic, PRESCALE=4, period=2: expire after edges 8, 16, 24.
        start_valid = 1'b1; start_period = 2; start_periodic = 1'b1;
        for (int k = 0; k <= 30; k++) begin
            push("periodic", ((k % 8) < 4) ? 2 : 1, 1'b1, (k > 0) && (k % 8 == 0));
            step(0);
            start_valid = 1'b0;
        end
        stop = 1'b1;
        push("periodic_stop", 0, 1'b0, 1'b0);
        step(0);
        stop = 1'b0;
        for (int k = 32; k <= 34; k++) begin
            push("periodic_idle", 0, 1'b0, 1'b0);
            step(0);
        end
        pulse_reset();

        // Stop on the terminal tick suppresses expire, PRESCALE=2, period=1.
        start_valid = 1'b1; start_period = 1; start_periodic = 1'b0;
        push("collide_accept", 1, 1'b1, 1'b0);
        step(1);
        start_valid = 1'b0;
        push("collide_run", 1, 1'b1, 1'b0);
        step(1);
        stop = 1'b1;
        push("collide_stop", 0, 1'b0, 1'b0);
        step(1);
        stop = 1'b0;
        push("collide_after", 0, 1'b0, 1'b0);
        step(1);
        pulse_reset();

        // Zero period runs as one tick; a start held during RUN loads later.
        start_valid = 1'b1; start_period = 0; start_periodic = 1'b0;
        push("zero_accept", 1, 1'b1, 1'b0);
        step(2);
        start_period = 9;
        push("zero_expire", 0, 1'b0, 1'b1);
        step(2);
        push("held_accept", 9, 1'b1, 1'b0);
        step(2);
        start_valid = 1'b0;
        push("held_run", 8, 1'b1, 1'b0);
        step(2);
        pulse_reset();

        // PRESCALE=1, period=1 periodic: expire held high until stop.
        start_valid = 1'b1; start_period = 1; start_periodic = 1'b1;
        push("degen_accept", 1, 1'b1, 1'b0);
        step(2);
        start_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            push("degen_run", 1, 1'b1, 1'b1);
            step(2);
        end
        stop = 1'b1;
        push("degen_stop", 0, 1'b0, 1'b0);
        step(2);
        stop = 1'b0;

        vectors++;
        assert (exp_q.size() == 0) else begin
            miscompares++;
            $error("FAIL scoreboard_drain: observed %0d left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
